// File: rtl/nbit_pipelined_mac.sv
// Pipelined multiply-accumulate: sign-magnitude shift-add multiplier consuming CHUNK
// multiplier bits per stage, feeding a saturating or wrapping signed accumulator.
module nbit_pipelined_mac #(
  parameter int MULTIPLIER_SIZE   = 8,
  parameter int MULTIPLICAND_SIZE = 4,
  parameter int CHUNK             = 2,
  parameter int ACC_WIDTH         = 20,
  parameter int SATURATE          = 1
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [MULTIPLIER_SIZE-1:0]                  multiplier,
  input  logic [MULTIPLICAND_SIZE-1:0]                multiplicand,
  input  logic                                        load,
  input  logic                                        is_signed,
  input  logic                                        acc_clear,
  input  logic                                        hold,
  output logic [MULTIPLIER_SIZE+MULTIPLICAND_SIZE-1:0] product,
  output logic                                        load_out,
  output logic [ACC_WIDTH-1:0]                        acc_out,
  output logic                                        acc_valid,
  output logic                                        overflow
);
  localparam int P      = MULTIPLIER_SIZE + MULTIPLICAND_SIZE;
  localparam int STAGES = MULTIPLIER_SIZE / CHUNK;

  logic                         w_negA;
  logic                         w_negB;
  logic [MULTIPLIER_SIZE-1:0]   w_magA;
  logic [MULTIPLICAND_SIZE-1:0] w_magB;

  logic [MULTIPLIER_SIZE-1:0]   r_magA [0:STAGES-1];
  logic [MULTIPLICAND_SIZE-1:0] r_magB [0:STAGES-1];
  logic [P-1:0]                 r_psum [1:STAGES];
  logic [P-1:0]                 w_pp   [1:STAGES];
  logic [P-1:0]                 w_next [1:STAGES];
  logic [STAGES:0]              r_valid;
  logic [STAGES:0]              r_sign;
  logic [STAGES:0]              r_signed;
  logic [STAGES:0]              r_clear;

  logic [P-1:0]                 r_result;
  logic                         r_resValid;
  logic                         r_resSigned;
  logic                         r_resClear;
  logic [P-1:0]                 r_product;
  logic                         r_prodValid;
  logic                         r_prodSigned;
  logic                         r_prodClear;

  logic [ACC_WIDTH-1:0]         r_acc;
  logic                         r_accValid;
  logic                         r_ovf;
  logic [ACC_WIDTH-1:0]         w_ext;
  logic [ACC_WIDTH:0]           w_sum;
  logic                         w_addOvf;
  logic [ACC_WIDTH-1:0]         w_accNext;

  // Unsigned negation of the most-negative value yields 2^(N-1), which still fits N bits.
  assign w_negA = is_signed & multiplier[MULTIPLIER_SIZE-1];
  assign w_negB = is_signed & multiplicand[MULTIPLICAND_SIZE-1];
  assign w_magA = w_negA ? -multiplier : multiplier;
  assign w_magB = w_negB ? -multiplicand : multiplicand;

  generate
    for (genvar g = 1; g <= STAGES; g++) begin : g_stage
      assign w_pp[g] = ({{(P-MULTIPLICAND_SIZE){1'b0}}, r_magB[g-1]} *
                        {{(P-CHUNK){1'b0}}, r_magA[g-1][(g-1)*CHUNK +: CHUNK]}) << ((g-1)*CHUNK);
      if (g == 1) begin : g_first
        assign w_next[g] = w_pp[g];
      end else begin : g_rest
        assign w_next[g] = r_psum[g-1] + w_pp[g];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid  <= '0;
      r_sign   <= '0;
      r_signed <= '0;
      r_clear  <= '0;
      for (int s = 0; s < STAGES; s++) begin
        r_magA[s] <= '0;
        r_magB[s] <= '0;
      end
      for (int s = 1; s <= STAGES; s++) r_psum[s] <= '0;
    end else if (!hold) begin
      r_valid   <= {r_valid[STAGES-1:0], load};
      r_sign    <= {r_sign[STAGES-1:0], w_negA ^ w_negB};
      r_signed  <= {r_signed[STAGES-1:0], is_signed};
      r_clear   <= {r_clear[STAGES-1:0], acc_clear};
      r_magA[0] <= w_magA;
      r_magB[0] <= w_magB;
      for (int s = 1; s < STAGES; s++) begin
        r_magA[s] <= r_magA[s-1];
        r_magB[s] <= r_magB[s-1];
      end
      for (int s = 1; s <= STAGES; s++) r_psum[s] <= w_next[s];
    end
  end

  // Signed add one bit wider than the accumulator so overflow shows as a top-bit disagreement.
  assign w_ext    = r_prodSigned ? {{(ACC_WIDTH-P){r_product[P-1]}}, r_product}
                                 : {{(ACC_WIDTH-P){1'b0}}, r_product};
  assign w_sum    = {r_acc[ACC_WIDTH-1], r_acc} + {w_ext[ACC_WIDTH-1], w_ext};
  assign w_addOvf = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];

  always_comb begin
    w_accNext = w_sum[ACC_WIDTH-1:0];
    if (w_addOvf && (SATURATE != 0)) begin
      w_accNext = w_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                   : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_result     <= '0;
      r_resValid   <= 1'b0;
      r_resSigned  <= 1'b0;
      r_resClear   <= 1'b0;
      r_product    <= '0;
      r_prodValid  <= 1'b0;
      r_prodSigned <= 1'b0;
      r_prodClear  <= 1'b0;
      r_acc        <= '0;
      r_accValid   <= 1'b0;
      r_ovf        <= 1'b0;
    end else if (!hold) begin
      r_result     <= r_sign[STAGES] ? -r_psum[STAGES] : r_psum[STAGES];
      r_resValid   <= r_valid[STAGES];
      r_resSigned  <= r_signed[STAGES];
      r_resClear   <= r_clear[STAGES];
      if (r_resValid) r_product <= r_result;
      r_prodValid  <= r_resValid;
      r_prodSigned <= r_resSigned;
      r_prodClear  <= r_resClear;
      r_accValid   <= r_prodValid;
      if (r_prodValid) begin
        if (r_prodClear) begin
          r_acc <= w_ext;
          r_ovf <= 1'b0;
        end else begin
          r_acc <= w_accNext;
          r_ovf <= r_ovf | w_addOvf;
        end
      end
    end
  end

  assign product   = r_product;
  assign load_out  = r_prodValid & ~hold;
  assign acc_out   = r_acc;
  assign acc_valid = r_accValid & ~hold;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_nbit_pipelined_mac.sv
// Drives three MAC instances (wide saturating, narrow saturating, narrow wrapping) with
// directed and random samples and compares every output against an arithmetic model.
module tb_nbit_pipelined_mac;
  localparam int LAT = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic        isSigned;
  logic        accClear;
  logic        hold;
  logic [7:0]  multiplier;
  logic [3:0]  multiplicand;
  logic [11:0] prodO [3];
  logic        loadOutO [3];
  logic        accValidO [3];
  logic        ovfO [3];
  logic [19:0] accA;
  logic [12:0] accB;
  logic [12:0] accC;

  int     accW [3]   = '{20, 13, 13};
  bit     accSat [3] = '{1'b1, 1'b1, 1'b0};
  longint expProd [int];
  longint expAcc [int];
  bit     expOvf [int];
  longint runAcc [3];
  bit     runOvf [3];
  longint shownAcc [3];
  bit     shownOvf [3];
  int     adv;
  bit     justReset;
  int     testsRun;
  int     testsFailed;

  always #5 clk = ~clk;

  nbit_pipelined_mac dutA (
    .clk(clk), .reset(reset), .multiplier(multiplier), .multiplicand(multiplicand),
    .load(load), .is_signed(isSigned), .acc_clear(accClear), .hold(hold),
    .product(prodO[0]), .load_out(loadOutO[0]), .acc_out(accA),
    .acc_valid(accValidO[0]), .overflow(ovfO[0]));

  nbit_pipelined_mac #(.ACC_WIDTH(13), .SATURATE(1)) dutB (
    .clk(clk), .reset(reset), .multiplier(multiplier), .multiplicand(multiplicand),
    .load(load), .is_signed(isSigned), .acc_clear(accClear), .hold(hold),
    .product(prodO[1]), .load_out(loadOutO[1]), .acc_out(accB),
    .acc_valid(accValidO[1]), .overflow(ovfO[1]));

  nbit_pipelined_mac #(.ACC_WIDTH(13), .SATURATE(0)) dutC (
    .clk(clk), .reset(reset), .multiplier(multiplier), .multiplicand(multiplicand),
    .load(load), .is_signed(isSigned), .acc_clear(accClear), .hold(hold),
    .product(prodO[2]), .load_out(loadOutO[2]), .acc_out(accC),
    .acc_valid(accValidO[2]), .overflow(ovfO[2]));

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle: check outputs against the model, take the edge, then advance the model.
  task automatic applyStimulus(input bit ld, input bit sgn, input bit clr, input bit hld,
                               input bit rstN, input logic [7:0] a, input logic [3:0] b);
    longint accObs [3];
    longint val;
    longint sum;
    longint lim;
    bit     expLo;
    bit     expAv;
    reset = rstN; load = ld; isSigned = sgn; accClear = clr; hold = hld;
    multiplier = a; multiplicand = b;
    #1;
    accObs[0] = longint'($signed(accA));
    accObs[1] = longint'($signed(accB));
    accObs[2] = longint'($signed(accC));
    expLo = !hld && expProd.exists(adv - LAT);
    expAv = !hld && expProd.exists(adv - LAT - 1);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("loadOut[%0d]", i), longint'(loadOutO[i]), longint'(expLo));
      if (expLo) checkOutput($sformatf("product[%0d]", i), longint'(prodO[i]), expProd[adv - LAT]);
      if (justReset) checkOutput($sformatf("rstProduct[%0d]", i), longint'(prodO[i]), 0);
      checkOutput($sformatf("accValid[%0d]", i), longint'(accValidO[i]), longint'(expAv));
      checkOutput($sformatf("acc[%0d]", i), accObs[i], shownAcc[i]);
      checkOutput($sformatf("overflow[%0d]", i), longint'(ovfO[i]), longint'(shownOvf[i]));
    end
    justReset = 1'b0;
    @(posedge clk);
    if (!rstN) begin
      expProd.delete();
      expAcc.delete();
      expOvf.delete();
      for (int i = 0; i < 3; i++) begin
        runAcc[i] = 0; runOvf[i] = 1'b0; shownAcc[i] = 0; shownOvf[i] = 1'b0;
      end
      justReset = 1'b1;
    end else if (!hld) begin
      adv++;
      if (ld) begin
        val = sgn ? longint'($signed(a)) * longint'($signed(b)) : longint'(a) * longint'(b);
        expProd[adv] = val & 64'hFFF;
        for (int i = 0; i < 3; i++) begin
          if (clr) begin
            runAcc[i] = val;
            runOvf[i] = 1'b0;
          end else begin
            sum = runAcc[i] + val;
            lim = longint'(1) << (accW[i] - 1);
            if (sum >= lim || sum < -lim) begin
              runOvf[i] = 1'b1;
              if (accSat[i]) sum = (sum >= lim) ? lim - 1 : -lim;
              else begin
                sum = sum & ((lim << 1) - 1);
                if (sum >= lim) sum = sum - (lim << 1);
              end
            end
            runAcc[i] = sum;
          end
          expAcc[adv*4 + i] = runAcc[i];
          expOvf[adv*4 + i] = runOvf[i];
        end
      end
      if (expProd.exists(adv - LAT - 1)) begin
        for (int i = 0; i < 3; i++) begin
          shownAcc[i] = expAcc[(adv - LAT - 1)*4 + i];
          shownOvf[i] = expOvf[(adv - LAT - 1)*4 + i];
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'h0);
  endtask

  initial begin
    testsRun = 0; testsFailed = 0; adv = 0; justReset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      runAcc[i] = 0; runOvf[i] = 1'b0; shownAcc[i] = 0; shownOvf[i] = 1'b0;
    end
    reset = 1'b0; load = 1'b0; isSigned = 1'b0; accClear = 1'b0; hold = 1'b0;
    multiplier = '0; multiplicand = '0;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
    idle(2);

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd7, 4'd2);
    idle(8);
    checkOutput("t1Acc", longint'($signed(accA)), 14);

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd7, 4'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 4'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd6, 4'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd7, 4'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd200, 4'd15);
    idle(8);
    checkOutput("t2Acc", longint'($signed(accA)), 3061);

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h80, 4'h8);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 4'hF);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 4'hF);
    idle(8);
    checkOutput("t3Acc", longint'($signed(accA)), 4844);

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd255, 4'd15);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd255, 4'd15);
    idle(8);
    checkOutput("t4SatAcc", longint'($signed(accB)), 4095);
    checkOutput("t4SatOvf", longint'(ovfO[1]), 1);
    checkOutput("t4WrapAcc", longint'($signed(accC)), -542);
    checkOutput("t4WideAcc", longint'($signed(accA)), 7650);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 4'd1);
    idle(8);
    checkOutput("t4ClrAcc", longint'($signed(accB)), 1);
    checkOutput("t4ClrOvf", longint'(ovfO[1]), 0);

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3, 4'd4);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5, 4'd6);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd99, 4'd9);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd99, 4'd9);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd99, 4'd9);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd7, 4'd8);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd9, 4'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd10, 4'd3);
    idle(4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 4'd0);
    idle(6);
    checkOutput("t5Acc", longint'($signed(accA)), 146);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd11, 4'd5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd12, 4'd5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd13, 4'd5);
    idle(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 4'd0);
    checkOutput("t6RstAcc", longint'($signed(accA)), 0);
    checkOutput("t6RstOvf", longint'(ovfO[1]), 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 4'd3);
    idle(8);
    checkOutput("t6Acc", longint'($signed(accA)), 6);

    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 63) != 0, 8'($urandom), 4'($urandom));
    end
    idle(10);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
